// File: rtl/marquee_led_engine.sv
// rtl/marquee_led_engine.sv - parametrised LED marquee pattern generator
//
// Purpose: drives N_LED outputs with one of five patterns (ALT, FILL,
// CONVERGE, BOUNCE, COUNT) or OFF. A runtime prescaler sets the tick rate.
// A one-cycle strobe marks each wrap of the pattern sequence.
//
// Optional feature macro: MARQUEE_PWM_EN (adds duty[3:0] brightness gating).
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   mode[2:0]  in   0 ALT, 1 FILL, 2 CONVERGE, 3 BOUNCE, 4 COUNT, 5-7 OFF
//   speed      in   tick period minus one, in clk cycles (compared live)
//   pause      in   holds prescaler and pattern state while high
//   duty[3:0]  in   (MARQUEE_PWM_EN only) brightness, 0 dark .. 15 full
//   led        out  LED drive, bit 0 = first LED
//   cycle_done out  one-cycle pulse on the tick that wraps the sequence
module marquee_led_engine #(
  parameter int N_LED = 26,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] speed,
  input  logic             pause,
`ifdef MARQUEE_PWM_EN
  input  logic [3:0]       duty,
`endif
  output logic [N_LED-1:0] led,
  output logic             cycle_done
);

  localparam int SW = $clog2(2 * N_LED);
  localparam int H  = (N_LED + 1) / 2;

  localparam logic [2:0] M_ALT    = 3'd0;
  localparam logic [2:0] M_FILL   = 3'd1;
  localparam logic [2:0] M_CONV   = 3'd2;
  localparam logic [2:0] M_BOUNCE = 3'd3;
  localparam logic [2:0] M_COUNT  = 3'd4;

  localparam logic [SW-1:0] N_S     = SW'(N_LED);
  localparam logic [SW-1:0] N1_S    = SW'(N_LED - 1);
  localparam logic [SW-1:0] N2_S    = SW'(N_LED - 2);
  localparam logic [SW-1:0] H_S     = SW'(H);
  localparam logic [SW-1:0] FILL_LS = SW'(2 * N_LED - 1);
  localparam logic [SW-1:0] CONV_LS = SW'(2 * H - 1);

  localparam logic [N_LED-1:0]   LED_ONE  = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [2*N_LED-1:0] ALT_WIDE = {N_LED{2'b01}};
  localparam logic [N_LED-1:0]   ALT_INIT = ALT_WIDE[N_LED-1:0];

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [2:0]       r_mode_q;
  logic [DIV_W-1:0] r_div;
  logic [SW-1:0]    r_step;
  dir_t             r_dir;
  logic [N_LED-1:0] r_led;
  logic             r_done;

  logic             w_tick;
  logic [N_LED-1:0] w_led_nx;
  logic [N_LED-1:0] w_led_init;
  logic [SW-1:0]    w_step_nx;
  logic [SW-1:0]    w_cv_off;
  dir_t             w_dir_nx;
  logic             w_done_nx;

  assign w_tick   = (r_div == speed);
  assign w_cv_off = r_step - H_S;

  // Next pattern state, applied only on a tick.
  always_comb begin
    w_led_nx   = r_led;
    w_step_nx  = r_step;
    w_dir_nx   = r_dir;
    w_done_nx  = 1'b0;
    w_led_init = '0;
    if (mode == M_ALT)    w_led_init = ALT_INIT;
    if (mode == M_BOUNCE) w_led_init = LED_ONE;
    case (r_mode_q)
      M_ALT: begin
        w_led_nx  = ~r_led;
        w_done_nx = (~r_led == ALT_INIT);
      end
      M_FILL: begin
        if (r_step < N_S) w_led_nx = r_led | (LED_ONE << r_step);
        else              w_led_nx = r_led & ~(LED_ONE << (r_step - N_S));
        if (r_step == FILL_LS) begin
          w_step_nx = '0;
          w_done_nx = 1'b1;
        end else begin
          w_step_nx = r_step + SW'(1);
        end
      end
      M_CONV: begin
        // Both halves are merged into one mask so the middle LED of an odd
        // strip gets a single consistent value.
        if (r_step < H_S)
          w_led_nx = r_led | (LED_ONE << r_step) | (LED_ONE << (N1_S - r_step));
        else
          w_led_nx = r_led & ~((LED_ONE << w_cv_off) | (LED_ONE << (N1_S - w_cv_off)));
        if (r_step == CONV_LS) begin
          w_step_nx = '0;
          w_done_nx = 1'b1;
        end else begin
          w_step_nx = r_step + SW'(1);
        end
      end
      M_BOUNCE: begin
        // r_step holds the lit position; the ends turn around immediately.
        if (r_dir == DIR_UP) begin
          if (r_step == N1_S) begin
            w_step_nx = N2_S;
            w_dir_nx  = DIR_DOWN;
          end else begin
            w_step_nx = r_step + SW'(1);
          end
        end else begin
          if (r_step == '0) begin
            w_step_nx = SW'(1);
            w_dir_nx  = DIR_UP;
            w_done_nx = 1'b1;
          end else begin
            w_step_nx = r_step - SW'(1);
          end
        end
        w_led_nx = LED_ONE << w_step_nx;
      end
      M_COUNT: begin
        w_led_nx  = r_led + LED_ONE;
        w_done_nx = &r_led;
      end
      default: w_led_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q <= 3'b111;
      r_div    <= '0;
      r_step   <= '0;
      r_dir    <= DIR_UP;
      r_led    <= '0;
      r_done   <= 1'b0;
    end else if (mode != r_mode_q) begin
      r_mode_q <= mode;
      r_div    <= '0;
      r_step   <= '0;
      r_dir    <= DIR_UP;
      r_led    <= w_led_init;
      r_done   <= 1'b0;
    end else if (pause) begin
      r_done   <= 1'b0;
    end else if (w_tick) begin
      r_div    <= '0;
      r_step   <= w_step_nx;
      r_dir    <= w_dir_nx;
      r_led    <= w_led_nx;
      r_done   <= w_done_nx;
    end else begin
      r_div    <= r_div + DIV_W'(1);
      r_done   <= 1'b0;
    end
  end

`ifdef MARQUEE_PWM_EN
  logic [3:0] r_pwm_cnt;
  logic       w_pwm_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pwm_cnt <= '0;
    else     r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end

  assign w_pwm_on = (duty > r_pwm_cnt) || (duty == 4'hF);
  assign led      = r_led & {N_LED{w_pwm_on}};
`else
  assign led      = r_led;
`endif

  assign cycle_done = r_done;

endmodule

// File: tb/tb_marquee_led_engine.sv
// tb/tb_marquee_led_engine.sv - self-checking bench for marquee_led_engine
module tb_marquee_led_engine;

  localparam int NI = 4;
  localparam int NS [NI] = '{8, 7, 26, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic [23:0] speed;
  logic        pause;
`ifdef MARQUEE_PWM_EN
  logic [3:0]  duty = 4'hF;
`endif

  logic [7:0]  led8;
  logic [6:0]  led7;
  logic [25:0] led26;
  logic [1:0]  led2;
  logic        d8, d7, d26, d2;

  logic [31:0] act_led  [NI];
  logic        act_done [NI];

  always #5 clk = ~clk;

  marquee_led_engine #(.N_LED(8), .DIV_W(24)) u_n8 (
    .clk(clk), .rst(rst), .mode(mode), .speed(speed), .pause(pause),
`ifdef MARQUEE_PWM_EN
    .duty(duty),
`endif
    .led(led8), .cycle_done(d8));

  marquee_led_engine #(.N_LED(7), .DIV_W(24)) u_n7 (
    .clk(clk), .rst(rst), .mode(mode), .speed(speed), .pause(pause),
`ifdef MARQUEE_PWM_EN
    .duty(duty),
`endif
    .led(led7), .cycle_done(d7));

  marquee_led_engine #(.N_LED(26), .DIV_W(24)) u_n26 (
    .clk(clk), .rst(rst), .mode(mode), .speed(speed), .pause(pause),
`ifdef MARQUEE_PWM_EN
    .duty(duty),
`endif
    .led(led26), .cycle_done(d26));

  marquee_led_engine #(.N_LED(2), .DIV_W(24)) u_n2 (
    .clk(clk), .rst(rst), .mode(mode), .speed(speed), .pause(pause),
`ifdef MARQUEE_PWM_EN
    .duty(duty),
`endif
    .led(led2), .cycle_done(d2));

  always_comb begin
    act_led[0]  = 32'(led8);
    act_led[1]  = 32'(led7);
    act_led[2]  = 32'(led26);
    act_led[3]  = 32'(led2);
    act_done[0] = d8;
    act_done[1] = d7;
    act_done[2] = d26;
    act_done[3] = d2;
  end

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  // Reference: active cycles since the pattern was (re)loaded and ticks taken.
  int     m_mode_q;
  longint m_a;
  longint m_k;
  bit     m_tick;

  // Pattern after k ticks, derived directly from the sequence definitions.
  function automatic logic [31:0] exp_led(int m, longint k, int n);
    longint mask, v, s, h, p, r, d;
    mask = (64'd1 << n) - 1;
    v    = 0;
    case (m)
      0: begin
        for (int i = 0; i < n; i += 2) v |= (64'd1 << i);
        if (k % 2 == 1) v = mask & ~v;
      end
      1: begin
        s = k % (2 * n);
        if (s <= n) v = (64'd1 << s) - 1;
        else        v = mask & ~((64'd1 << (s - n)) - 1);
      end
      2: begin
        h = (n + 1) / 2;
        s = k % (2 * h);
        for (int i = 0; i < n; i++) begin
          d = (i < n - 1 - i) ? i : n - 1 - i;
          if ((s <= h && d < s) || (s > h && d >= s - h)) v |= (64'd1 << i);
        end
      end
      3: begin
        p = 2 * n - 2;
        r = k % p;
        v = 64'd1 << ((r <= n - 1) ? r : p - r);
      end
      4: v = k & mask;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic exp_done(int m, longint k, bit tick, int n);
    longint h, p;
    if (!tick) return 1'b0;
    h = (n + 1) / 2;
    p = 2 * n - 2;
    case (m)
      0: return (k % 2) == 0;
      1: return (k % (2 * n)) == 0;
      2: return (k % (2 * h)) == 0;
      3: return (k >= p + 1) && ((k - 1) % p == 0);
      4: return (k % (64'd1 << n)) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic advance();
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_mode_q = 7; m_a = 0; m_k = 0; m_tick = 0;
    end else if (int'(mode) != m_mode_q) begin
      m_mode_q = int'(mode); m_a = 0; m_k = 0; m_tick = 0;
    end else if (pause) begin
      m_tick = 0;
    end else begin
      m_a++;
      m_tick = (m_a % (longint'(speed) + 1)) == 0;
      if (m_tick) m_k++;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int j = 0; j < NI; j++) begin
      checks++;
      if (act_led[j] !== 32'd0) begin
        failures++;
        $display("FAIL reset_led N=%0d got=%h exp=0", NS[j], act_led[j]);
      end
      checks++;
      if (act_done[j] !== 1'b0) begin
        failures++;
        $display("FAIL reset_done N=%0d got=%b exp=0", NS[j], act_done[j]);
      end
    end
    rst = 1'b0;
    repeat (3) advance();
    for (int j = 0; j < NI; j++) begin
      checks++;
      if (act_led[j] !== 32'd0) begin
        failures++;
        $display("FAIL off_after_reset N=%0d got=%h exp=0", NS[j], act_led[j]);
      end
    end
  endtask

  task automatic test_pattern(input logic [2:0] m, input logic [23:0] sp, input int ncyc);
    mode = m; speed = sp; pause = 1'b0;
    repeat (ncyc) begin
      advance();
      for (int j = 0; j < NI; j++) begin
        checks++;
        if (act_led[j] !== exp_led(m_mode_q, m_k, NS[j])) begin
          failures++;
          $display("FAIL pattern_led mode=%0d N=%0d cyc=%0d got=%h exp=%h",
                   m_mode_q, NS[j], cyc, act_led[j], exp_led(m_mode_q, m_k, NS[j]));
        end
        checks++;
        if (act_done[j] !== exp_done(m_mode_q, m_k, m_tick, NS[j])) begin
          failures++;
          $display("FAIL pattern_done mode=%0d N=%0d cyc=%0d got=%b exp=%b",
                   m_mode_q, NS[j], cyc, act_done[j], exp_done(m_mode_q, m_k, m_tick, NS[j]));
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    mode = 3'd4; speed = 24'd3; pause = 1'b0;
    repeat (30) advance();
    mode = 3'd0;
    repeat (12) begin
      advance();
      for (int j = 0; j < NI; j++) begin
        checks++;
        if (act_led[j] !== exp_led(m_mode_q, m_k, NS[j])) begin
          failures++;
          $display("FAIL switch_led N=%0d cyc=%0d got=%h exp=%h",
                   NS[j], cyc, act_led[j], exp_led(m_mode_q, m_k, NS[j]));
        end
        checks++;
        if (act_done[j] !== exp_done(m_mode_q, m_k, m_tick, NS[j])) begin
          failures++;
          $display("FAIL switch_done N=%0d cyc=%0d got=%b", NS[j], cyc, act_done[j]);
        end
      end
    end
  endtask

  task automatic test_pause();
    mode = 3'd4; speed = 24'd0; pause = 1'b0;
    repeat (20) advance();
    for (int c = 0; c < 60; c++) begin
      pause = (c < 40);
      advance();
      for (int j = 0; j < NI; j++) begin
        checks++;
        if (act_led[j] !== exp_led(m_mode_q, m_k, NS[j])) begin
          failures++;
          $display("FAIL pause_led N=%0d cyc=%0d got=%h exp=%h",
                   NS[j], cyc, act_led[j], exp_led(m_mode_q, m_k, NS[j]));
        end
        checks++;
        if (act_done[j] !== exp_done(m_mode_q, m_k, m_tick, NS[j])) begin
          failures++;
          $display("FAIL pause_done N=%0d cyc=%0d got=%b", NS[j], cyc, act_done[j]);
        end
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] nm;
    for (int seg = 0; seg < 25; seg++) begin
      nm = 3'($urandom_range(0, 7));
      // speed only moves together with a mode change, which clears the prescaler
      if (int'(nm) != m_mode_q) speed = 24'($urandom_range(0, 3));
      mode = nm;
      for (int c = 0; c < int'($urandom_range(10, 60)); c++) begin
        pause = ($urandom_range(0, 4) == 0);
        advance();
        for (int j = 0; j < NI; j++) begin
          checks++;
          if (act_led[j] !== exp_led(m_mode_q, m_k, NS[j])) begin
            failures++;
            $display("FAIL random_led mode=%0d N=%0d cyc=%0d got=%h exp=%h",
                     m_mode_q, NS[j], cyc, act_led[j], exp_led(m_mode_q, m_k, NS[j]));
          end
          checks++;
          if (act_done[j] !== exp_done(m_mode_q, m_k, m_tick, NS[j])) begin
            failures++;
            $display("FAIL random_done mode=%0d N=%0d cyc=%0d got=%b",
                     m_mode_q, NS[j], cyc, act_done[j]);
          end
        end
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_reset_mid();
    mode = 3'd3; speed = 24'd0; pause = 1'b0;
    repeat (9) advance();
    rst = 1'b1;
    #1;
    for (int j = 0; j < NI; j++) begin
      checks++;
      if (act_led[j] !== 32'd0 || act_done[j] !== 1'b0) begin
        failures++;
        $display("FAIL async_reset N=%0d got=%h/%b exp=0/0", NS[j], act_led[j], act_done[j]);
      end
    end
    advance();
    rst = 1'b0;
    repeat (6) begin
      advance();
      for (int j = 0; j < NI; j++) begin
        checks++;
        if (act_led[j] !== exp_led(m_mode_q, m_k, NS[j])) begin
          failures++;
          $display("FAIL after_reset_led N=%0d cyc=%0d got=%h exp=%h",
                   NS[j], cyc, act_led[j], exp_led(m_mode_q, m_k, NS[j]));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 3'd7; speed = 24'd0; pause = 1'b0;
    m_mode_q = 7; m_a = 0; m_k = 0; m_tick = 0;
    repeat (2) advance();
    test_reset();
    test_pattern(3'd1, 24'd0, 40);
    test_pattern(3'd2, 24'd0, 30);
    test_pattern(3'd3, 24'd2, 200);
    test_pattern(3'd0, 24'd1, 20);
    test_mode_switch();
    test_pause();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
